// File: rtl/core_trace_pkg.sv
// Shared types and constants for the commit-side trace generator and its checkers.
package core_trace_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;

    localparam logic [31:0] ECALL_OPCODE = 32'h00000073;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SLEEP
    } wfi_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     opcode;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            iexception;
    } trace_rec_t;

endpackage

// File: rtl/core_trace_gen_if.sv
// Commit, WFI-control and trace-sink signals of core_trace_gen.
interface core_trace_gen_if #(
    parameter int unsigned CNT_W = 16
);
    import core_trace_pkg::*;

    logic            cmt_valid;
    logic [XLEN-1:0] cmt_pc;
    logic [31:0]     cmt_instr;
    logic            cmt_excp;
    logic [XLEN-1:0] cmt_cause;
    logic [XLEN-1:0] cmt_tval;
    logic            cmt_wfi;
    logic            wake_req;
    logic            lsu_idle;
    logic            trace_ready;

    logic             trace_ivalid;
    logic [XLEN-1:0]  trace_pc;
    logic [31:0]      trace_opcode;
    logic [XLEN-1:0]  trace_cause;
    logic [XLEN-1:0]  trace_tval;
    logic             trace_iexception;
    logic             trace_full;
    logic [CNT_W-1:0] trace_drop_cnt;
    logic             core_wfi_mode;

    // Core/sink side: drives commits and sink readiness, observes the trace stream.
    modport master (
        output cmt_valid, cmt_pc, cmt_instr, cmt_excp, cmt_cause, cmt_tval, cmt_wfi,
        output wake_req, lsu_idle, trace_ready,
        input  trace_ivalid, trace_pc, trace_opcode, trace_cause, trace_tval,
        input  trace_iexception, trace_full, trace_drop_cnt, core_wfi_mode
    );

    modport slave (
        input  cmt_valid, cmt_pc, cmt_instr, cmt_excp, cmt_cause, cmt_tval, cmt_wfi,
        input  wake_req, lsu_idle, trace_ready,
        output trace_ivalid, trace_pc, trace_opcode, trace_cause, trace_tval,
        output trace_iexception, trace_full, trace_drop_cnt, core_wfi_mode
    );

endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; caller guarantees no push when full without pop, no pop when empty.
module trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/core_trace_gen.sv
// Commit-side trace generator: buffers retire records for the trace sink and runs the WFI sleep FSM.
module core_trace_gen
    import core_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    core_trace_gen_if.slave bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    trace_rec_t     wr_rec;
    trace_rec_t     rd_rec;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           drop;
    logic [CNT_W-1:0] drop_cnt_q;
    wfi_state_e     state_q;
    wfi_state_e     state_d;

    always_comb begin
        wr_rec            = '0;
        wr_rec.pc         = bus.cmt_pc;
        wr_rec.opcode     = bus.cmt_instr;
        wr_rec.iexception = bus.cmt_excp;
        if (bus.cmt_excp) begin
            wr_rec.cause = bus.cmt_cause;
            wr_rec.tval  = bus.cmt_tval;
        end
    end

    // A simultaneous pop frees a slot, so a full FIFO only drops when the sink stalls.
    assign pop  = !fifo_empty && bus.trace_ready;
    assign drop = bus.cmt_valid && (fifo_count == CW'(FIFO_DEPTH)) && !pop;
    assign push = bus.cmt_valid && !drop;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(trace_rec_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (rd_rec),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Commits seen outside RUN are protocol violations; they are traced but ignored here.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (bus.cmt_valid && bus.cmt_wfi && !bus.cmt_excp && !bus.wake_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.wake_req) begin
                    state_d = RUN;
                end else if (bus.lsu_idle) begin
                    state_d = SLEEP;
                end
            end
            SLEEP: begin
                if (bus.wake_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.trace_ivalid     = !fifo_empty;
    assign bus.trace_pc         = rd_rec.pc;
    assign bus.trace_opcode     = rd_rec.opcode;
    assign bus.trace_cause      = rd_rec.cause;
    assign bus.trace_tval       = rd_rec.tval;
    assign bus.trace_iexception = rd_rec.iexception;
    assign bus.trace_full       = fifo_full;
    assign bus.trace_drop_cnt   = drop_cnt_q;
    assign bus.core_wfi_mode    = (state_q == SLEEP);

endmodule
